// File: rtl/datapath_pkg.sv
// Shared types and constants for the 8-bit register-file datapath.
// The opcode enum, SYS sub-codes and flag positions are used by both the top and the ALU.
package datapath_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_REGS  = 4;
    localparam int REG_SEL_W = 2;
    localparam int FLAG_W    = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_SYS  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ADC  = 4'h4,
        OP_SUB  = 4'h5,
        OP_SBC  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_XOR  = 4'h9,
        OP_NOT  = 4'hA,
        OP_SHL  = 4'hB,
        OP_SHR  = 4'hC,
        OP_ASR  = 4'hD,
        OP_ADDI = 4'hE,
        OP_CMP  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        SYS_NOP       = 2'b00,
        SYS_OUT_REG   = 2'b01,
        SYS_OUT_FLAGS = 2'b10,
        SYS_NOP_ALT   = 2'b11
    } sys_e;

    // Per-command side effects reported by the ALU.
    typedef struct packed {
        logic wr_reg;
        logic wr_out;
        logic upd_nz;
        logic upd_c;
        logic upd_v;
    } alu_ctrl_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: one shared 9-bit adder serves ADD/ADC/ADDI/SUB/SBC/CMP.
// Subtraction is a + ~b + cin, so the carry out is directly the "no borrow" flag.
module datapath_alu
    import datapath_pkg::*;
(
    input  opcode_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    output logic [DATA_W-1:0]   res,
    output logic                c,
    output logic                v,
    output alu_ctrl_t           ctrl
);

    logic              is_sub;
    logic              add_ci;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum9;
    logic              v_arith;

    assign is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    assign b_eff  = is_sub ? ~b : b;

    always_comb begin
        add_ci = 1'b0;
        case (op)
            OP_SUB, OP_CMP: add_ci = 1'b1;
            OP_ADC, OP_SBC: add_ci = cin;
            default:        add_ci = 1'b0;
        endcase
    end

    assign sum9 = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, add_ci};
    // With b inverted for subtraction, "same sign in, different sign out" covers both cases.
    assign v_arith = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum9[DATA_W-1] != a[DATA_W-1]);

    always_comb begin
        res  = '0;
        c    = cin;
        v    = 1'b0;
        ctrl = '0;
        case (op)
            OP_SYS: ;
            OP_LDI, OP_MOV: begin
                res         = b;
                ctrl.wr_reg = 1'b1;
                ctrl.wr_out = 1'b1;
            end
            OP_ADD, OP_ADC, OP_ADDI, OP_SUB, OP_SBC, OP_CMP: begin
                res         = sum9[DATA_W-1:0];
                c           = sum9[DATA_W];
                v           = v_arith;
                ctrl.wr_reg = (op != OP_CMP);
                ctrl.wr_out = (op != OP_CMP);
                ctrl.upd_nz = 1'b1;
                ctrl.upd_c  = 1'b1;
                ctrl.upd_v  = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (op)
                    OP_AND:  res = a & b;
                    OP_OR:   res = a | b;
                    OP_XOR:  res = a ^ b;
                    default: res = ~b;
                endcase
                ctrl.wr_reg = 1'b1;
                ctrl.wr_out = 1'b1;
                ctrl.upd_nz = 1'b1;
                ctrl.upd_v  = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
                case (op)
                    OP_SHL: begin
                        res = {b[DATA_W-2:0], 1'b0};
                        c   = b[DATA_W-1];
                    end
                    OP_SHR: begin
                        res = {1'b0, b[DATA_W-1:1]};
                        c   = b[0];
                    end
                    default: begin
                        res = {b[DATA_W-1], b[DATA_W-1:1]};
                        c   = b[0];
                    end
                endcase
                ctrl.wr_reg = 1'b1;
                ctrl.wr_out = 1'b1;
                ctrl.upd_nz = 1'b1;
                ctrl.upd_c  = 1'b1;
                ctrl.upd_v  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// TinyTapeout tile top: 4x8 register file, NZCV flags and a registered OUT port.
// rst_n is an active-high synchronous reset despite its harness-given name.
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    output logic [DATA_W-1:0] uo_out,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [FLAG_W-1:0]               flags;
    logic [DATA_W-1:0]               out_q;

    opcode_e            op;
    sys_e               sys_op;
    logic [REG_SEL_W-1:0] rd;
    logic [REG_SEL_W-1:0] rs;
    logic [DATA_W-1:0]  opnd_a;
    logic [DATA_W-1:0]  opnd_b;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_c;
    logic               alu_v;
    alu_ctrl_t          alu_ctrl;
    logic [DATA_W-1:0]  out_d;
    logic [FLAG_W-1:0]  flags_d;

    assign op     = opcode_e'(ui_in[7:4]);
    assign rd     = ui_in[3:2];
    assign rs     = ui_in[1:0];
    assign sys_op = sys_e'(rs);

    assign opnd_a = regs[rd];
    assign opnd_b = ((op == OP_LDI) || (op == OP_ADDI)) ? uio_in : regs[rs];

    datapath_alu u_alu (
        .op   (op),
        .a    (opnd_a),
        .b    (opnd_b),
        .cin  (flags[FLAG_C]),
        .res  (alu_res),
        .c    (alu_c),
        .v    (alu_v),
        .ctrl (alu_ctrl)
    );

    always_comb begin
        out_d = out_q;
        if (op == OP_SYS) begin
            case (sys_op)
                SYS_OUT_REG:   out_d = regs[rd];
                SYS_OUT_FLAGS: out_d = {{(DATA_W-FLAG_W){1'b0}}, flags};
                default:       out_d = out_q;
            endcase
        end else if (alu_ctrl.wr_out) begin
            out_d = alu_res;
        end
    end

    always_comb begin
        flags_d = flags;
        if (alu_ctrl.upd_nz) begin
            flags_d[FLAG_N] = alu_res[DATA_W-1];
            flags_d[FLAG_Z] = (alu_res == '0);
        end
        if (alu_ctrl.upd_c) flags_d[FLAG_C] = alu_c;
        if (alu_ctrl.upd_v) flags_d[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            regs  <= '0;
            flags <= '0;
            out_q <= '0;
        end else if (ena) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (alu_ctrl.wr_reg && (rd == REG_SEL_W'(i))) regs[i] <= alu_res;
            end
            flags <= flags_d;
            out_q <= out_d;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_datapath.sv
// Random and directed stimulus against an integer-arithmetic reference model of the datapath.
module tb_datapath;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 0;

    logic [7:0] m_r [4];
    logic [7:0] m_out;
    bit fN, fZ, fC, fV;

    datapath dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] cmd(input int op, input int rd, input int rs);
        return {4'(op), 2'(rd), 2'(rs)};
    endfunction

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference behaviour from the instruction-set rules, using plain integers.
    task automatic model_step(input bit r, input bit e, input logic [7:0] c, input logic [7:0] im);
        int op, rd, rs, a, b, s, ss, res, ci;
        op = int'(c[7:4]); rd = int'(c[3:2]); rs = int'(c[1:0]);
        if (r) begin
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
            {fN, fZ, fC, fV} = 4'b0;
            m_out = 8'h00;
            return;
        end
        if (!e) return;
        a = int'(m_r[rd]);
        b = (op == 1 || op == 14) ? int'(im) : int'(m_r[rs]);
        res = 0;
        case (op)
            0: begin
                if (rs == 1) m_out = m_r[rd];
                else if (rs == 2) m_out = {4'b0, fN, fZ, fC, fV};
                return;
            end
            1, 2: begin
                m_r[rd] = 8'(b);
                m_out   = 8'(b);
                return;
            end
            3, 4, 14: begin
                ci  = (op == 4) ? int'(fC) : 0;
                s   = a + b + ci;
                ss  = sgn(a) + sgn(b) + ci;
                res = s % 256;
                fC  = (s > 255);
                fV  = (ss > 127) || (ss < -128);
            end
            5, 6, 15: begin
                ci  = (op == 6) ? 1 - int'(fC) : 0;
                s   = a - b - ci;
                ss  = sgn(a) - sgn(b) - ci;
                res = (s + 512) % 256;
                fC  = (s >= 0);
                fV  = (ss > 127) || (ss < -128);
            end
            7:  begin res = a & b;       fV = 0; end
            8:  begin res = a | b;       fV = 0; end
            9:  begin res = a ^ b;       fV = 0; end
            10: begin res = 255 - b;     fV = 0; end
            11: begin res = (b * 2) % 256; fC = (b >= 128); fV = 0; end
            12: begin res = b / 2;       fC = (b % 2 == 1); fV = 0; end
            default: begin res = b / 2 + ((b >= 128) ? 128 : 0); fC = (b % 2 == 1); fV = 0; end
        endcase
        fN = (res >= 128);
        fZ = (res == 0);
        if (op != 15) begin
            m_r[rd] = 8'(res);
            m_out   = 8'(res);
        end
    endtask

    task automatic apply(input bit r, input bit e, input logic [7:0] c, input logic [7:0] im);
        rst_n  = r;
        ena    = e;
        ui_in  = c;
        uio_in = im;
        @(posedge clk);
        #1;
        model_step(r, e, c, im);
    endtask

    task automatic lit(input string name, input logic [7:0] exp);
        @(negedge clk);
        vectors++;
        if (uo_out !== exp) begin
            miscompares++;
            $display("FAIL %s: uo_out=%02h required %02h", name, uo_out, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (uo_out !== m_out || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t: uo_out=%02h uio_out=%02h uio_oe=%02h required %02h/00/00",
                         $time, uo_out, uio_out, uio_oe, m_out);
            end
        end
    end

    initial begin
        rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_out = 8'h00;
        {fN, fZ, fC, fV} = 4'b0;
        @(negedge clk);

        apply(1, 1, 8'($urandom), 8'($urandom));
        apply(1, 0, 8'($urandom), 8'($urandom));
        chk_on = 1;
        lit("reset_out", 8'h00);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("reset_flags", 8'h00);

        apply(0, 1, cmd(1, 0, 0), 8'h7F);
        apply(0, 1, cmd(1, 1, 0), 8'h01);
        apply(0, 1, cmd(3, 0, 1), 8'h00);        lit("add_7f_01", 8'h80);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("add_flags", 8'h09);

        apply(0, 1, cmd(1, 2, 0), 8'h10);
        apply(0, 1, cmd(1, 3, 0), 8'h20);
        apply(0, 1, cmd(5, 2, 3), 8'h00);        lit("sub_10_20", 8'hF0);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("sub_flags", 8'h08);
        apply(0, 1, cmd(4, 2, 3), 8'h00);        lit("adc_f0_20", 8'h10);
        apply(0, 1, cmd(15, 2, 2), 8'h00);       lit("cmp_holds_out", 8'h10);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("cmp_flags", 8'h06);

        apply(0, 1, cmd(1, 1, 0), 8'h81);
        apply(0, 1, cmd(13, 0, 1), 8'h00);       lit("asr_81", 8'hC0);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("asr_flags", 8'h0A);
        apply(0, 1, cmd(12, 0, 1), 8'h00);       lit("shr_81", 8'h40);
        apply(0, 1, cmd(11, 0, 1), 8'h00);       lit("shl_81", 8'h02);
        apply(0, 1, cmd(0, 0, 2), 8'h00);        lit("shl_flags", 8'h02);

        apply(0, 1, cmd(1, 0, 0), 8'h3C);
        apply(0, 0, cmd(1, 0, 0), 8'h55);        lit("ena0_hold", 8'h3C);
        apply(0, 1, cmd(0, 0, 1), 8'h00);        lit("ena0_r0", 8'h3C);

        apply(1, 1, cmd(1, 0, 0), 8'hAA);        lit("reset_vs_ldi", 8'h00);
        apply(0, 1, cmd(0, 0, 1), 8'h00);        lit("reset_r0", 8'h00);

        apply(0, 1, cmd(1, 1, 0), 8'h05);
        apply(0, 1, cmd(3, 1, 1), 8'h00);        lit("add_self", 8'h0A);

        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                  8'($urandom), 8'($urandom));
        end
        @(negedge clk);
        chk_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
